// File: rtl/reg_file_rename_pkg.sv
// Shared types and constants for the rename-tagged architectural register file.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package reg_file_rename_pkg;

  localparam int REG_NUM_DEF       = 32;
  localparam int DATA_WIDTH_DEF    = 32;
  localparam int ROB_POS_WIDTH_DEF = 4;

  // Register index is fixed at 5 bits to match the decoder fields.
  typedef logic [4:0]                   REG_POS_TYPE;
  typedef logic [DATA_WIDTH_DEF-1:0]    DATA_TYPE;
  // ROB tag including the wrap/valid MSB produced by the ROB.
  typedef logic [ROB_POS_WIDTH_DEF:0]   ROB_WRAP_POS_TYPE;
  typedef logic [ROB_POS_WIDTH_DEF-1:0] ROB_POS_TYPE;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

endpackage

// File: rtl/reg_file_rename.sv
// Architectural register file with per-register ROB rename tags; x0 reads as zero.
// Latency: commit/issue visible on read ports next cycle (same-cycle commit value with REG_COMMIT_BYPASS_EN).
// Backpressure: rdy=0 freezes all state; read ports stay combinationally valid.
module reg_file_rename
  import reg_file_rename_pkg::*;
#(
  parameter int REG_NUM       = REG_NUM_DEF,
  parameter int DATA_WIDTH    = DATA_WIDTH_DEF,
  parameter int ROB_POS_WIDTH = ROB_POS_WIDTH_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rdy,
  input  logic                     rollback,
  input  logic                     issue_enable,
  input  REG_POS_TYPE              issue_rd,
  input  logic [ROB_POS_WIDTH:0]   issue_rob_pos,
  input  logic                     reg_commit_enable,
  input  REG_POS_TYPE              reg_pos,
  input  logic [DATA_WIDTH-1:0]    reg_val,
  input  logic [ROB_POS_WIDTH:0]   commit_rob_pos,
  input  REG_POS_TYPE              rs1_pos,
  input  REG_POS_TYPE              rs2_pos,
  output logic                     rs1_busy,
  output logic                     rs2_busy,
  output logic [DATA_WIDTH-1:0]    rs1_val,
  output logic [DATA_WIDTH-1:0]    rs2_val,
  output logic [ROB_POS_WIDTH:0]   rs1_rob_pos,
  output logic [ROB_POS_WIDTH:0]   rs2_rob_pos
);

  typedef struct packed {
    logic                   busy;
    logic [ROB_POS_WIDTH:0] tag;
    logic [DATA_WIDTH-1:0]  val;
  } read_t;

  logic [DATA_WIDTH-1:0]  val_q  [REG_NUM];
  logic                   busy_q [REG_NUM];
  logic [ROB_POS_WIDTH:0] tag_q  [REG_NUM];

  read_t rs1_rd;
  read_t rs2_rd;

  // One read port: registered state, optionally overlaid with the committing write.
  function automatic read_t lookup(input REG_POS_TYPE pos);
    read_t r;
    r = '0;
    if (pos != '0) begin
      r.busy = busy_q[pos];
      r.tag  = tag_q[pos];
      r.val  = val_q[pos];
`ifdef REG_COMMIT_BYPASS_EN
      // Forward the committing value; retire busy only when the commit is the live producer.
      if (reg_commit_enable && (reg_pos == pos)) begin
        r.val = reg_val;
        if (busy_q[pos] && (tag_q[pos] == commit_rob_pos)) begin
          r.busy = FALSE;
        end
      end
`endif
    end
    return r;
  endfunction

  // Source-1 lookup.
  always_comb begin
    rs1_rd = lookup(rs1_pos);
  end

  // Source-2 lookup.
  always_comb begin
    rs2_rd = lookup(rs2_pos);
  end

  assign rs1_busy    = rs1_rd.busy;
  assign rs1_rob_pos = rs1_rd.tag;
  assign rs1_val     = rs1_rd.val;
  assign rs2_busy    = rs2_rd.busy;
  assign rs2_rob_pos = rs2_rd.tag;
  assign rs2_val     = rs2_rd.val;

  // State update: commit first, then rollback flush, then issue so issue wins busy/tag.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < REG_NUM; i++) begin
        val_q[i]  <= '0;
        busy_q[i] <= FALSE;
        tag_q[i]  <= '0;
      end
    end else if (rdy) begin
      if (reg_commit_enable && (reg_pos != '0)) begin
        val_q[reg_pos] <= reg_val;
        // A stale tag means a younger producer is still in flight: keep busy.
        if (busy_q[reg_pos] && (tag_q[reg_pos] == commit_rob_pos)) begin
          busy_q[reg_pos] <= FALSE;
        end
      end
      if (rollback) begin
        for (int i = 0; i < REG_NUM; i++) begin
          busy_q[i] <= FALSE;
          tag_q[i]  <= '0;
        end
      end else if (issue_enable && (issue_rd != '0)) begin
        busy_q[issue_rd] <= TRUE;
        tag_q[issue_rd]  <= issue_rob_pos;
      end
    end
  end

endmodule

// File: tb/tb_reg_file_rename.sv
// Directed bench for reg_file_rename with a scoreboard of expected read results.
// Latency: reads sampled 1ns after inputs settle, state updates checked after the next edge.
// Backpressure: exercises rdy=0 freeze.
module tb_reg_file_rename;

  logic        clk = 1'b0;
  logic        rst, rdy, rollback, issue_enable, reg_commit_enable;
  logic [4:0]  issue_rd, reg_pos, rs1_pos, rs2_pos;
  logic [4:0]  issue_rob_pos, commit_rob_pos;
  logic [31:0] reg_val;
  logic        rs1_busy, rs2_busy;
  logic [31:0] rs1_val, rs2_val;
  logic [4:0]  rs1_rob_pos, rs2_rob_pos;

  typedef struct {
    string       name;
    int          port;
    logic        busy;
    logic [31:0] val;
    logic [4:0]  tag;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  reg_file_rename dut (
    .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback),
    .issue_enable(issue_enable), .issue_rd(issue_rd), .issue_rob_pos(issue_rob_pos),
    .reg_commit_enable(reg_commit_enable), .reg_pos(reg_pos), .reg_val(reg_val),
    .commit_rob_pos(commit_rob_pos), .rs1_pos(rs1_pos), .rs2_pos(rs2_pos),
    .rs1_busy(rs1_busy), .rs2_busy(rs2_busy), .rs1_val(rs1_val), .rs2_val(rs2_val),
    .rs1_rob_pos(rs1_rob_pos), .rs2_rob_pos(rs2_rob_pos)
  );

  // Advance one clock edge, then drop all one-shot strobes.
  task automatic step();
    @(posedge clk);
    #1;
    issue_enable      = 1'b0;
    reg_commit_enable = 1'b0;
    rollback          = 1'b0;
  endtask

  // Drive a read address, queue the expectation, then compare once the read settles.
  task automatic read_chk(input string name, input int port, input logic [4:0] pos,
                          input logic busy, input logic [31:0] val, input logic [4:0] tag);
    exp_t e;
    exp_t g;
    logic        ob;
    logic [31:0] ov;
    logic [4:0]  ot;
    if (port == 1) rs1_pos = pos; else rs2_pos = pos;
    e.name = name; e.port = port; e.busy = busy; e.val = val; e.tag = tag;
    exp_q.push_back(e);
    #1;
    g = exp_q.pop_front();
    ob = (g.port == 1) ? rs1_busy    : rs2_busy;
    ov = (g.port == 1) ? rs1_val     : rs2_val;
    ot = (g.port == 1) ? rs1_rob_pos : rs2_rob_pos;
    checks++;
    assert (ob === g.busy) else begin
      errors++;
      $error("FAIL %s busy: got %b want %b", g.name, ob, g.busy);
    end
    checks++;
    assert (ov === g.val) else begin
      errors++;
      $error("FAIL %s val: got %h want %h", g.name, ov, g.val);
    end
    checks++;
    assert (ot === g.tag) else begin
      errors++;
      $error("FAIL %s rob_pos: got %b want %b", g.name, ot, g.tag);
    end
  endtask

  task automatic issue(input logic [4:0] rd, input logic [4:0] tag);
    issue_enable = 1'b1; issue_rd = rd; issue_rob_pos = tag;
  endtask

  task automatic commit(input logic [4:0] rd, input logic [31:0] v, input logic [4:0] tag);
    reg_commit_enable = 1'b1; reg_pos = rd; reg_val = v; commit_rob_pos = tag;
  endtask

  initial begin
    rst = 1'b1; rdy = 1'b1; rollback = 1'b0;
    issue_enable = 1'b0; issue_rd = '0; issue_rob_pos = '0;
    reg_commit_enable = 1'b0; reg_pos = '0; reg_val = '0; commit_rob_pos = '0;
    rs1_pos = '0; rs2_pos = '0;
    step(); step();
    rst = 1'b0;

    read_chk("reset_r5",  1, 5'd5,  1'b0, 32'h0, 5'b00000);
    read_chk("reset_r31", 2, 5'd31, 1'b0, 32'h0, 5'b00000);

    issue(5'd3, 5'b10010); step();
    read_chk("issue_r3", 1, 5'd3, 1'b1, 32'h0, 5'b10010);
    commit(5'd3, 32'hDEADBEEF, 5'b10010); step();
    read_chk("commit_r3", 2, 5'd3, 1'b0, 32'hDEADBEEF, 5'b10010);

    issue(5'd7, 5'b10001); step();
    issue(5'd7, 5'b10100); step();
    commit(5'd7, 32'h11, 5'b10001); step();
    read_chk("stale_commit_r7", 2, 5'd7, 1'b1, 32'h11, 5'b10100);

    issue(5'd4, 5'b10110); commit(5'd4, 32'h22, 5'b10011); step();
    read_chk("same_cycle_r4", 1, 5'd4, 1'b1, 32'h22, 5'b10110);
    issue(5'd4, 5'b11000); commit(5'd4, 32'h23, 5'b10110); step();
    read_chk("issue_wins_r4", 2, 5'd4, 1'b1, 32'h23, 5'b11000);

    issue(5'd1, 5'b10001); step();
    issue(5'd2, 5'b10010); step();
    issue(5'd9, 5'b10011); step();
    read_chk("pre_rb_r9", 1, 5'd9, 1'b1, 32'h0, 5'b10011);
    rollback = 1'b1; commit(5'd2, 32'h33, 5'b00000); issue(5'd6, 5'b10101); step();
    read_chk("rb_r1", 1, 5'd1, 1'b0, 32'h0,        5'b00000);
    read_chk("rb_r2", 2, 5'd2, 1'b0, 32'h33,       5'b00000);
    read_chk("rb_r9", 1, 5'd9, 1'b0, 32'h0,        5'b00000);
    read_chk("rb_r6", 2, 5'd6, 1'b0, 32'h0,        5'b00000);
    read_chk("rb_r7", 1, 5'd7, 1'b0, 32'h11,       5'b00000);
    read_chk("rb_r3", 2, 5'd3, 1'b0, 32'hDEADBEEF, 5'b00000);

    issue(5'd0, 5'b11111); commit(5'd0, 32'hFF, 5'b11111); step();
    read_chk("x0_rs1", 1, 5'd0, 1'b0, 32'h0, 5'b00000);
    read_chk("x0_rs2", 2, 5'd0, 1'b0, 32'h0, 5'b00000);

    rdy = 1'b0; issue(5'd5, 5'b10111); commit(5'd5, 32'h55, 5'b10111); step();
    rdy = 1'b1;
    read_chk("rdy_low_r5", 1, 5'd5, 1'b0, 32'h0, 5'b00000);

    issue(5'd3, 5'b11001); step();
    commit(5'd3, 32'h44, 5'b11001);
`ifdef REG_COMMIT_BYPASS_EN
    read_chk("bypass_r3", 1, 5'd3, 1'b0, 32'h44, 5'b11001);
`else
    read_chk("no_bypass_r3", 1, 5'd3, 1'b1, 32'hDEADBEEF, 5'b11001);
`endif
    read_chk("other_port_r7", 2, 5'd7, 1'b0, 32'h11, 5'b00000);
    step();
    read_chk("post_commit_r3", 1, 5'd3, 1'b0, 32'h44, 5'b11001);

    rst = 1'b1; step(); rst = 1'b0;
    read_chk("rst_again_r3", 1, 5'd3, 1'b0, 32'h0, 5'b00000);
    read_chk("rst_again_r4", 2, 5'd4, 1'b0, 32'h0, 5'b00000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/reg_file_rename.md
Name: reg_file_rename

Overview:
- Architectural register file with per-register rename tags for the Tomasulo core.
- Receives ROB commit writes (reg_commit_enable / reg_pos / reg_val / commit_rob_pos).
- Records the producing ROB entry when the decoder issues an instruction with rd.
- Answers decoder operand lookups with either a committed value or the ROB tag to query.
- Drops all renames on rollback.

Parameters:
- REG_NUM, 32, number of architectural registers; x0 hardwired to zero.
- DATA_WIDTH, 32, register value width.
- ROB_POS_WIDTH, 4, ROB index width; tags are ROB_POS_WIDTH+1 bits, MSB = valid/wrap bit as produced by the ROB.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- rdy  in  1  global ready; low = freeze all state
- rollback  in  1  misprediction flush from ROB
- issue_enable  in  1  decoder issues an instruction that writes rd
- issue_rd  in  5  destination register of issued instruction
- issue_rob_pos  in  ROB_POS_WIDTH+1  ROB tag allocated to it (next_rob_pos)
- reg_commit_enable  in  1  ROB commit write strobe
- reg_pos  in  5  committed destination register
- reg_val  in  DATA_WIDTH  committed value
- commit_rob_pos  in  ROB_POS_WIDTH+1  tag of committing entry
- rs1_pos  in  5  decoder source-1 index
- rs2_pos  in  5  decoder source-2 index
- rs1_busy  out  1  rs1 has an outstanding producer
- rs2_busy  out  1  rs2 has an outstanding producer
- rs1_val  out  DATA_WIDTH  committed value of rs1
- rs2_val  out  DATA_WIDTH  committed value of rs2
- rs1_rob_pos  out  ROB_POS_WIDTH+1  producer tag of rs1, valid when busy
- rs2_rob_pos  out  ROB_POS_WIDTH+1  producer tag of rs2, valid when busy

Behaviour:
- Reset rst, synchronous, active-high; clock clk.
- Reset clears every val, busy and tag to 0.
- Read ports are combinational, so all outputs are 0 after reset.
- Per-register state: val[DATA_WIDTH], busy[1], tag[ROB_POS_WIDTH+1].
- Read ports:
  - rsX_busy = busy[rsX_pos]; rsX_rob_pos = tag[rsX_pos]; rsX_val = val[rsX_pos].
  - rsX_pos == 0 always gives busy 0, val 0.
- Per cycle, when rdy=1 and rst=0:
  - Commit: if reg_commit_enable and reg_pos != 0, write val[reg_pos] <= reg_val.
  - Commit also clears busy[reg_pos] iff busy is set and tag[reg_pos] == commit_rob_pos. A stale tag writes the value but keeps busy.
  - Issue: if issue_enable, issue_rd != 0 and rollback=0, set busy[issue_rd] <= 1 and tag[issue_rd] <= issue_rob_pos.
  - Issue and commit to the same register in the same cycle: value is written, and issue wins busy/tag (busy stays 1 with the new tag).
  - Rollback=1: all busy <= 0 and tags <= 0 next cycle. A commit in the same cycle still writes its value. A same-cycle issue is discarded.
- rdy=0: no state change; reads remain valid.
- Writes to x0 are ignored in every path.
- Latency: a commit or issue is visible on the read ports the next cycle, unless the bypass below is enabled.
- Rollback mid-chain: a later commit for a flushed tag cannot occur, because the ROB is flushed in the same cycle. No tag guard beyond the equality check is required.

Optional Feature:
- Macro: REG_COMMIT_BYPASS_EN.
- Defined:
  - If reg_commit_enable && reg_pos == rsX_pos && rsX_pos != 0, rsX_val = reg_val in the same cycle.
  - If additionally busy && tag == commit_rob_pos, rsX_busy = 0.
  - Same-cycle issue is not bypassed; the decoder handles its own rd hazard.
- Undefined: reads reflect registered state only; one-cycle commit-to-read latency.

Decomposition:
- Shared package/definition header holds REG_POS_TYPE, DATA_TYPE, ROB_WRAP_POS_TYPE, ROB_POS_TYPE, TRUE/FALSE.
- Single module; the read-port lookup (including bypass) is one small function/always block instantiated twice.
- No sub-module.

Test Plan:
- Reset, then read rs1_pos=5 -> busy 0, val 0, rob_pos 0.
- Issue rd=3, tag=5'b10010; next cycle read 3 -> busy 1, rob_pos 10010. Commit reg_pos=3, val=0xDEADBEEF, tag 10010; next cycle -> busy 0, val 0xDEADBEEF.
- Issue rd=7 tag 10001, then issue rd=7 tag 10100. Commit rd=7 tag 10001 val=0x11 -> val 0x11, busy 1, rob_pos 10100.
- Same cycle: issue rd=4 tag 10110 and commit rd=4 tag 10011 val=0x22 -> val 0x22, busy 1, tag 10110.
- Issue rd=1,2,9. Assert rollback with a commit rd=2 val=0x33 and an issue rd=6 -> all busy 0, val[2]=0x33, rd 6 not busy.
- Issue/commit to rd=0 -> x0 reads 0, not busy. rdy=0 during an issue -> no change. With REG_COMMIT_BYPASS_EN, commit rd=3 val=0x44 while reading 3 -> same-cycle val 0x44, busy 0.
